bcd_counter: RTL and testbench
==============================

BCD_COUNTER -- requirements
Module: bcd_counter

Interface
REQ-001 SHALL have parameter DIGITS, default 6: number of BCD digits (range 1..8).
REQ-002 SHALL have parameter TICK_MAX, default 5_000_000: clk cycles per auto-step (100 ms at 50 MHz); minimum 2.
REQ-003 SHALL have parameter SAT, default 0: 0 = wrap at limits, 1 = saturate at limits.
REQ-004 SHALL have ports: clk input 1 (system clock); rst_n input 1 (reset, asynchronous, active-low).
REQ-005 SHALL have ports: run input 1 (enables tick divider); up_dn input 1 (1 = count up, 0 = count down).
REQ-006 SHALL have ports: inc input 1 (single-step pulse); clr input 1 (synchronous clear).
REQ-007 SHALL have ports: load input 1 (synchronous load strobe); load_val input 4*DIGITS (BCD value to load).
REQ-008 SHALL have ports: data output 4*DIGITS (BCD count, digit 0 in bits [3:0]); point output DIGITS (decimal points).
REQ-009 SHALL have ports: en output 1 (display enable); sign output 1 (minus sign); blank output DIGITS (leading-zero mask); wrap output 1 (limit-crossing pulse).
REQ-010 Clock and reset SHALL be one clock, clk, with reset rst_n asynchronous and active-low.

Function
REQ-011 Divider counts 0..TICK_MAX-1 while run=1 and holds its value while run=0 (pause, no reset).
REQ-012 Internal tick SHALL pulse for 1 cycle in the cycle after the divider equals TICK_MAX-1; the divider then restarts at 0.
REQ-013 step = tick OR inc; simultaneous tick and inc SHALL count once.
REQ-014 Priority per cycle: clr > load > step; a lower-priority event in the same cycle is discarded.
REQ-015 clr: data <= 0 and divider <= 0 on the next edge.
REQ-016 load: data <= load_val on the next edge, with any digit > 9 clamped to 9; the divider is unaffected.
REQ-017 step with up_dn=1: decimal increment with ripple carry; data changes on the edge ending the step cycle.
REQ-018 step with up_dn=0: decimal decrement with ripple borrow.
REQ-019 Up at all-9s: SAT=0 wraps to 0; SAT=1 holds at all-9s.
REQ-020 Down at 0: SAT=0 wraps to all-9s; SAT=1 holds at 0.
REQ-021 wrap SHALL be high 1 cycle, registered with data, only when a wrap actually occurs; never with SAT=1.
REQ-022 blank[i] SHALL be 1 when digit i and all higher digits are 0, for i >= 1; blank[0] is always 0; blank is combinational from data.
REQ-023 point SHALL be 0 and sign SHALL be 0 at all times after reset; en SHALL be 1 from the first edge after reset release.
REQ-024 up_dn and run are sampled every cycle; changing them mid-count SHALL NOT corrupt data or the divider.

Reset
REQ-025 While rst_n=0: data=0, divider=0, tick=0, wrap=0, en=0, point=0, sign=0, immediately and asynchronously.
REQ-026 Reset asserted mid-count SHALL discard any pending step; the first tick after release comes TICK_MAX+1 cycles after run is high.

Structure
REQ-027 The shared package SHALL hold: BCD_W=4, the default TICK_MAX for the 50 MHz clock, and the digit max constant 9.
REQ-028 Sub-module bcd_digit SHALL implement one digit (inputs: digit, up_dn, carry/borrow in; outputs: next digit, carry/borrow out) and be instantiated DIGITS times via generate.
REQ-029 The divider width SHALL be $clog2(TICK_MAX) and SHALL NOT be hardcoded.

Verification (DIGITS=3, TICK_MAX=4 unless noted)
REQ-030 run=1, up_dn=1 from reset -> data 000, 001, 002 at 4-cycle spacing; run=0 for 10 cycles -> data frozen, and the count resumes with no lost phase.
REQ-031 load 0x998, then inc x2 -> 999, then 000 with wrap=1 for 1 cycle; SAT=1 -> stays 999, wrap never asserts.
REQ-032 load 0x000, up_dn=0, inc -> 999 with wrap pulse; SAT=1 -> stays 000.
REQ-033 clr, load 0x123 and inc all in one cycle -> data=000; load 0x1A5 -> data=0x195.
REQ-034 data=0x007 -> blank=3'b110; data=0x000 -> blank=3'b110; data=0x100 -> blank=3'b000.
REQ-035 rst_n low mid-count at data=0x042 -> all outputs 0 without a clock edge; after release, en=1 on the first edge and data counts from 000.

Source files
------------

// File: rtl/bcd_counter_pkg.sv
// Shared constants and helpers for the BCD counter and its digit cell.
package bcd_counter_pkg;

  localparam int BCD_W = 4;

  // 100 ms auto-step period at a 50 MHz system clock.
  localparam int DEFAULT_TICK_MAX = 5_000_000;

  localparam logic [BCD_W-1:0] DIGIT_MAX = 4'd9;

  // Values 10..15 are not valid BCD; the nearest legal digit is 9.
  function automatic logic [BCD_W-1:0] clamp_digit(input logic [BCD_W-1:0] d);
    return (d > DIGIT_MAX) ? DIGIT_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the counter: computes the next digit value and the
// carry (up) or borrow (down) handed to the next more significant digit.
module bcd_digit
  import bcd_counter_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  input  logic             up_dn,
  input  logic             cin,
  output logic [BCD_W-1:0] next_digit,
  output logic             cout
);

  // A digit only moves when the lower decades rippled into it.
  always_comb begin
    next_digit = digit;
    cout       = 1'b0;
    if (cin) begin
      if (up_dn) begin
        if (digit >= DIGIT_MAX) begin
          next_digit = '0;
          cout       = 1'b1;
        end else begin
          next_digit = digit + 4'd1;
        end
      end else begin
        if (digit == '0) begin
          next_digit = DIGIT_MAX;
          cout       = 1'b1;
        end else begin
          next_digit = digit - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_counter.sv
// Multi-digit BCD up/down counter with a free-running tick divider,
// single-step input, synchronous clear/load and leading-zero blanking.
module bcd_counter
  import bcd_counter_pkg::*;
#(
  parameter int DIGITS   = 6,
  parameter int TICK_MAX = DEFAULT_TICK_MAX,
  parameter bit SAT      = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    run,
  input  logic                    up_dn,
  input  logic                    inc,
  input  logic                    clr,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] load_val,
  output logic [BCD_W*DIGITS-1:0] data,
  output logic [DIGITS-1:0]       point,
  output logic                    en,
  output logic                    sign,
  output logic [DIGITS-1:0]       blank,
  output logic                    wrap
);

  localparam int               DIV_W    = $clog2(TICK_MAX);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_MAX - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic [DIV_W-1:0]        div_cnt;
  logic                    tick;
  logic                    step;
  logic [DIGITS:0]         carry;
  logic [BCD_W*DIGITS-1:0] data_next;
  logic [BCD_W*DIGITS-1:0] load_clamped;

  // Divider pauses in place when run drops so no phase is lost; tick is
  // registered so it lands in the cycle after the last divider count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (clr) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (run) begin
      tick    <= (div_cnt == DIV_LAST);
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_ONE;
    end else begin
      tick    <= 1'b0;
    end
  end

  assign step     = tick | inc;
  assign carry[0] = 1'b1;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : gen_digit
      bcd_digit u_digit (
        .digit      (data[g*BCD_W +: BCD_W]),
        .up_dn      (up_dn),
        .cin        (carry[g]),
        .next_digit (data_next[g*BCD_W +: BCD_W]),
        .cout       (carry[g+1])
      );
    end
  endgenerate

  // Clamp each loaded digit into the legal BCD range.
  always_comb begin
    load_clamped = '0;
    for (int i = 0; i < DIGITS; i++) begin
      load_clamped[i*BCD_W +: BCD_W] = clamp_digit(load_val[i*BCD_W +: BCD_W]);
    end
  end

  // Count register: clear beats load beats step; a carry out of the top
  // digit is a limit crossing, which either wraps or is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
      wrap <= 1'b0;
      en   <= 1'b0;
    end else begin
      en   <= 1'b1;
      wrap <= 1'b0;
      if (clr) begin
        data <= '0;
      end else if (load) begin
        data <= load_clamped;
      end else if (step) begin
        if (!(carry[DIGITS] && SAT)) begin
          data <= data_next;
          wrap <= carry[DIGITS];
        end
      end
    end
  end

  // Blank a digit when it and every digit above it are zero; the units
  // digit always shows.
  always_comb begin : blank_logic
    logic hi_zero;
    blank   = '0;
    hi_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      hi_zero  = hi_zero && (data[i*BCD_W +: BCD_W] == '0);
      blank[i] = hi_zero;
    end
  end

  assign point = '0;
  assign sign  = 1'b0;

endmodule

// File: tb/tb_bcd_counter.sv
// Directed bench for bcd_counter (3 digits, tick every 4 cycles), running
// a wrapping and a saturating instance side by side on shared stimulus.
module tb_bcd_counter;

  typedef struct {
    logic        clr;
    logic        load;
    logic [11:0] load_val;
    logic        inc;
    logic        up_dn;
    logic [11:0] exp_d0;
    logic        exp_w0;
    logic [11:0] exp_d1;
    logic        exp_w1;
    logic [2:0]  exp_b0;
  } vec_t;

  localparam int NVEC = 20;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        up_dn;
  logic        inc;
  logic        clr;
  logic        load;
  logic [11:0] load_val;

  logic [11:0] data0, data1;
  logic [2:0]  point0, point1, blank0, blank1;
  logic        en0, en1, sign0, sign1, wrap0, wrap1;

  int total = 0;
  int bad   = 0;

  vec_t vecs [NVEC];

  bcd_counter #(.DIGITS(3), .TICK_MAX(4), .SAT(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .run(run), .up_dn(up_dn), .inc(inc),
    .clr(clr), .load(load), .load_val(load_val), .data(data0),
    .point(point0), .en(en0), .sign(sign0), .blank(blank0), .wrap(wrap0)
  );

  bcd_counter #(.DIGITS(3), .TICK_MAX(4), .SAT(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .run(run), .up_dn(up_dn), .inc(inc),
    .clr(clr), .load(load), .load_val(load_val), .data(data1),
    .point(point1), .en(en1), .sign(sign1), .blank(blank1), .wrap(wrap1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [11:0] act,
                             input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    clr      = v.clr;
    load     = v.load;
    load_val = v.load_val;
    inc      = v.inc;
    up_dn    = v.up_dn;
    stepCycle();
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 12'h998, 1'b0, 1'b1, 12'h998, 1'b0, 12'h998, 1'b0, 3'b000};
    vecs[1]  = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h999, 1'b0, 12'h999, 1'b0, 3'b000};
    vecs[2]  = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h000, 1'b1, 12'h999, 1'b0, 3'b110};
    vecs[3]  = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 12'h000, 1'b0, 12'h999, 1'b0, 3'b110};
    vecs[4]  = '{1'b0, 1'b1, 12'h000, 1'b0, 1'b1, 12'h000, 1'b0, 12'h000, 1'b0, 3'b110};
    vecs[5]  = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 12'h999, 1'b1, 12'h000, 1'b0, 3'b000};
    vecs[6]  = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h999, 1'b0, 12'h000, 1'b0, 3'b000};
    vecs[7]  = '{1'b1, 1'b1, 12'h123, 1'b1, 1'b1, 12'h000, 1'b0, 12'h000, 1'b0, 3'b110};
    vecs[8]  = '{1'b0, 1'b1, 12'h1A5, 1'b0, 1'b1, 12'h195, 1'b0, 12'h195, 1'b0, 3'b000};
    vecs[9]  = '{1'b0, 1'b1, 12'h007, 1'b0, 1'b1, 12'h007, 1'b0, 12'h007, 1'b0, 3'b110};
    vecs[10] = '{1'b0, 1'b1, 12'h100, 1'b0, 1'b1, 12'h100, 1'b0, 12'h100, 1'b0, 3'b000};
    vecs[11] = '{1'b0, 1'b1, 12'h0FF, 1'b0, 1'b1, 12'h099, 1'b0, 12'h099, 1'b0, 3'b100};
    vecs[12] = '{1'b0, 1'b1, 12'h042, 1'b1, 1'b1, 12'h042, 1'b0, 12'h042, 1'b0, 3'b100};
    vecs[13] = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h043, 1'b0, 12'h043, 1'b0, 3'b100};
    vecs[14] = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 12'h042, 1'b0, 12'h042, 1'b0, 3'b100};
    vecs[15] = '{1'b0, 1'b1, 12'h109, 1'b0, 1'b1, 12'h109, 1'b0, 12'h109, 1'b0, 3'b000};
    vecs[16] = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h110, 1'b0, 12'h110, 1'b0, 3'b000};
    vecs[17] = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 12'h109, 1'b0, 12'h109, 1'b0, 3'b000};
    vecs[18] = '{1'b0, 1'b1, 12'hFFF, 1'b0, 1'b1, 12'h999, 1'b0, 12'h999, 1'b0, 3'b000};
    vecs[19] = '{1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 12'h000, 1'b0, 12'h000, 1'b0, 3'b110};

    rst_n    = 1'b0;
    run      = 1'b0;
    up_dn    = 1'b1;
    inc      = 1'b0;
    clr      = 1'b0;
    load     = 1'b0;
    load_val = 12'h000;

    #12;
    checkOutput("reset data",  data0, 12'h000);
    checkOutput("reset wrap",  12'(wrap0), 12'h0);
    checkOutput("reset en",    12'(en0), 12'h0);
    checkOutput("reset point", 12'(point0), 12'h0);
    checkOutput("reset sign",  12'(sign0), 12'h0);
    checkOutput("reset blank", 12'(blank0), 12'h6);
    checkOutput("reset sat data",  data1, 12'h000);
    checkOutput("reset sat en",    12'(en1), 12'h0);
    checkOutput("reset sat point", 12'(point1), 12'h0);
    checkOutput("reset sat sign",  12'(sign1), 12'h0);
    checkOutput("reset sat blank", 12'(blank1), 12'h6);

    // Auto count from reset: data advances on edges 5, 9, ...
    run   = 1'b1;
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      stepCycle();
      checkOutput($sformatf("run edge%0d data", k), data0, 12'((k - 1) / 4));
      if (k == 1) checkOutput("en after release", 12'(en0), 12'h1);
    end
    checkOutput("run blank", 12'(blank0), 12'h6);

    // Pause: data frozen, divider phase kept.
    run = 1'b0;
    for (int k = 0; k < 10; k++) begin
      stepCycle();
      checkOutput($sformatf("pause%0d data", k), data0, 12'h002);
    end
    run = 1'b1;
    stepCycle();
    stepCycle();
    checkOutput("resume before tick", data0, 12'h002);
    stepCycle();
    checkOutput("resume after tick", data0, 12'h003);
    checkOutput("resume sat data", data1, 12'h003);
    run = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d data", i), data0, vecs[i].exp_d0);
      checkOutput($sformatf("vec%0d wrap", i), 12'(wrap0), 12'(vecs[i].exp_w0));
      checkOutput($sformatf("vec%0d sat data", i), data1, vecs[i].exp_d1);
      checkOutput($sformatf("vec%0d sat wrap", i), 12'(wrap1), 12'(vecs[i].exp_w1));
      checkOutput($sformatf("vec%0d blank", i), 12'(blank0), 12'(vecs[i].exp_b0));
    end
    clr  = 1'b0;
    load = 1'b0;
    inc  = 1'b0;

    // Reset in the middle of a count with a step pending.
    load     = 1'b1;
    load_val = 12'h042;
    up_dn    = 1'b1;
    stepCycle();
    load = 1'b0;
    run  = 1'b1;
    stepCycle();
    stepCycle();
    checkOutput("midcount data", data0, 12'h042);
    #2;
    inc   = 1'b1;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset data", data0, 12'h000);
    checkOutput("async reset en",   12'(en0), 12'h0);
    checkOutput("async reset wrap", 12'(wrap0), 12'h0);
    checkOutput("async reset sat data", data1, 12'h000);
    checkOutput("async reset sat wrap", 12'(wrap1), 12'h0);
    inc = 1'b0;
    stepCycle();
    #2;
    rst_n = 1'b1;
    stepCycle();
    checkOutput("rerelease en",   12'(en0), 12'h1);
    checkOutput("rerelease data", data0, 12'h000);
    stepCycle();
    stepCycle();
    stepCycle();
    checkOutput("rerelease edge4 data", data0, 12'h000);
    stepCycle();
    checkOutput("rerelease edge5 data", data0, 12'h001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
